// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The accumulate state exists only when MULDIV_MADD_EN is defined.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMadd  = 3'b100,
        OpMaddu = 3'b101,
        OpMsub  = 3'b110,
        OpMsubu = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFix,
`ifdef MULDIV_MADD_EN
        StAcc,
`endif
        StDone
    } state_e;

    // Result-select for the single-iteration datapath.
    localparam logic StepMul = 1'b0;
    localparam logic StepDiv = 1'b1;

    function automatic logic op_is_div(op_e op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

    function automatic logic op_is_signed(op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_acc(op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_sub(op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] hi_in;
    logic [WIDTH-1:0] lo_in;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_zero;

    modport master (
        output start, op, op_a, op_b, hi_in, lo_in, cancel,
        input  busy, done, hi_out, lo_out, div_zero
    );

    modport slave (
        input  start, op, op_a, op_b, hi_in, lo_in, cancel,
        output busy, done, hi_out, lo_out, div_zero
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on {hi, lo}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             mode_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        shifted = {hi_i, lo_i[WIDTH-1]};
        diff    = shifted - {1'b0, b_i};
        if (mode_i == StepMul) begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            hi_o = diff[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
        end else begin
            // Trial subtraction borrowed: keep the shifted remainder.
            hi_o = shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative MIPS-style multiply/divide unit: WIDTH steps on magnitudes, then sign fix.
// Define MULDIV_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate stage.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_w_q, hi_w_d, lo_w_q, lo_w_d, b_q, b_d;
    logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             div_zero_q, div_zero_d, busy_q, busy_d, done_q, done_d;
`ifdef MULDIV_MADD_EN
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_res;
`else
    logic unused_acc;
    assign unused_acc = ^{bus.hi_in, bus.lo_in};
`endif

    op_e                in_op;
    logic               in_sa, in_sb, in_dz;
    logic [WIDTH-1:0]   mag_a, mag_b, step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, fix_res;

    assign in_op = op_e'(bus.op);
    assign in_sa = op_is_signed(in_op) & bus.op_a[WIDTH-1];
    assign in_sb = op_is_signed(in_op) & bus.op_b[WIDTH-1];
    assign mag_a = in_sa ? -bus.op_a : bus.op_a;
    assign mag_b = in_sb ? -bus.op_b : bus.op_b;
    assign in_dz = op_is_div(in_op) && (bus.op_b == '0);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i (op_is_div(op_q) ? StepDiv : StepMul),
        .hi_i   (hi_w_q),
        .lo_i   (lo_w_q),
        .b_i    (b_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    always_comb begin
        prod = {hi_w_q, lo_w_q};
        if (dz_q) begin
            fix_res = prod;
        end else if (op_is_div(op_q)) begin
            // Remainder follows the dividend sign, quotient the sign xor.
            fix_res = {(sa_q ? -hi_w_q : hi_w_q), ((sa_q ^ sb_q) ? -lo_w_q : lo_w_q)};
        end else begin
            fix_res = (sa_q ^ sb_q) ? -prod : prod;
        end
`ifdef MULDIV_MADD_EN
        acc_res = op_is_sub(op_q) ? acc_q - prod : acc_q + prod;
`endif
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        hi_w_d     = hi_w_q;
        lo_w_d     = lo_w_q;
        b_d        = b_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
`ifdef MULDIV_MADD_EN
        acc_d      = acc_q;
`endif
        if (bus.cancel) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (bus.start) begin
                        op_d   = in_op;
                        sa_d   = in_sa;
                        sb_d   = in_sb;
                        dz_d   = in_dz;
                        cnt_d  = '0;
                        hi_w_d = '0;
                        lo_w_d = op_is_div(in_op) ? mag_a : mag_b;
                        b_d    = op_is_div(in_op) ? mag_b : mag_a;
`ifdef MULDIV_MADD_EN
                        acc_d  = {bus.hi_in, bus.lo_in};
`endif
                        state_d = StRun;
                        if (in_dz) begin
                            hi_w_d  = bus.op_a;
                            lo_w_d  = '1;
                            state_d = StFix;
                        end
                    end
                end
                StRun: begin
                    hi_w_d = step_hi;
                    lo_w_d = step_lo;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
`ifdef MULDIV_MADD_EN
                    if (op_is_acc(op_q)) begin
                        {hi_w_d, lo_w_d} = fix_res;
                        state_d          = StAcc;
                    end else
`endif
                    begin
                        {hi_d, lo_d} = fix_res;
                        if (op_is_div(op_q)) begin
                            div_zero_d = dz_q;
                        end
                        state_d = StDone;
                    end
                end
`ifdef MULDIV_MADD_EN
                StAcc: begin
                    {hi_d, lo_d} = acc_res;
                    state_d      = StDone;
                end
`endif
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d == StRun) || (state_d == StFix);
`ifdef MULDIV_MADD_EN
        busy_d = busy_d || (state_d == StAcc);
`endif
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= OpMult;
            cnt_q      <= '0;
            hi_w_q     <= '0;
            lo_w_q     <= '0;
            b_q        <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            hi_w_q     <= hi_w_d;
            lo_w_q     <= lo_w_d;
            b_q        <= b_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef MULDIV_MADD_EN
            acc_q      <= acc_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed vector bench for muldiv_iter (WIDTH=32); expectations follow MULDIV_MADD_EN.
module tb_muldiv_iter;
    localparam int unsigned W = 32;
`ifdef MULDIV_MADD_EN
    localparam bit MaddEn = 1'b1;
`else
    localparam bit MaddEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi_in;
        logic [31:0] lo_in;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];
    int   tests = 0;
    int   fails = 0;
    bit   last_dz = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi_in, input logic [31:0] lo_in);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.hi_in = hi_in;
        bus.lo_in = lo_in;
    endtask

    // Counts edges after the accepting edge until done is seen; 0 on timeout.
    task automatic wait_done(input int first, output int lat);
        lat = 0;
        for (int n = first; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_in, input logic [31:0] lo_in, output int lat);
        @(negedge clk);
        drive(op, a, b, hi_in, lo_in);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(1, lat);
    endtask

    task automatic quiet(input string name, input int cycles);
        int seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        vecs[0]  = '{3'b000, 32'hFFFFFFFE, 32'h3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 33};
        vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h1, 33};
        vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{3'b011, 32'h64, 32'h0, 0, 0, 32'h64, 32'hFFFFFFFF, 1};
        vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h80000000, 33};
        vecs[5]  = '{3'b011, 32'h64, 32'h7, 0, 0, 32'h2, 32'hE, 33};
        vecs[6]  = '{3'b010, 32'h7, 32'hFFFFFFFE, 0, 0, 32'h1, 32'hFFFFFFFD, 33};
        vecs[7]  = '{3'b100, 32'h3, 32'h4, 32'h0, 32'hA, 32'h0,
                     MaddEn ? 32'h16 : 32'hC, MaddEn ? 34 : 33};
        vecs[8]  = '{3'b111, 32'h2, 32'h3, 32'h0, 32'h5, MaddEn ? 32'hFFFFFFFF : 32'h0,
                     MaddEn ? 32'hFFFFFFFF : 32'h6, MaddEn ? 34 : 33};
        vecs[9]  = '{3'b110, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, MaddEn ? 32'h0 : 32'hFFFFFFFF,
                     MaddEn ? 32'h2 : 32'hFFFFFFFE, MaddEn ? 34 : 33};
        vecs[10] = '{3'b101, 32'h1, 32'h1, 32'h1, 32'hFFFFFFFF, MaddEn ? 32'h2 : 32'h0,
                     MaddEn ? 32'h0 : 32'h1, MaddEn ? 34 : 33};
        vecs[11] = '{3'b010, 32'h0, 32'h0, 0, 0, 32'h0, 32'hFFFFFFFF, 1};
        vecs[12] = '{3'b000, 32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h0, 33};

        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        drive(3'b000, 0, 0, 0, 0);
        bus.start  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi_out, 0);
        check("rst_lo", bus.lo_out, 0);
        check("rst_dz", bus.div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi_in, vecs[i].lo_in, lat);
            if (vecs[i].op[2:1] == 2'b01) last_dz = (vecs[i].b == 0);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_hi", i), bus.hi_out, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), bus.lo_out, vecs[i].exp_lo);
            check($sformatf("v%0d_dz", i), bus.div_zero, last_dz);
        end

        // A start while busy must be ignored.
        @(negedge clk);
        drive(3'b001, 32'h3, 32'h3, 0, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy_mid", bus.busy, 1);
        @(negedge clk);
        drive(3'b011, 32'h64, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(11, lat);
        check("ign_lat", lat, 33);
        check("ign_lo", bus.lo_out, 32'h9);
        check("ign_hi", bus.hi_out, 32'h0);
        check("ign_dz", bus.div_zero, last_dz);

        // Cancel at edge 5 together with a new start.
        @(negedge clk);
        drive(3'b010, 32'h64, 32'h7, 0, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.cancel = 1'b1;
        drive(3'b011, 32'h5, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        check("cancel_busy", bus.busy, 0);
        check("cancel_done", bus.done, 0);
        quiet("cancel_quiet", 40);
        check("cancel_hi", bus.hi_out, 32'h0);
        check("cancel_lo", bus.lo_out, 32'h9);
        check("cancel_dz", bus.div_zero, last_dz);

        // Back-to-back: next start issued during the done cycle.
        run_op(3'b001, 32'h5, 32'h6, 0, 0, lat);
        check("b2b_first_lat", lat, 33);
        check("b2b_first_lo", bus.lo_out, 32'd30);
        drive(3'b001, 32'h7, 32'h8, 0, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_done_drop", bus.done, 0);
        check("b2b_busy", bus.busy, 1);
        wait_done(1, lat);
        check("b2b_second_lat", lat, 33);
        check("b2b_second_lo", bus.lo_out, 32'd56);
        check("b2b_second_hi", bus.hi_out, 32'h0);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        drive(3'b001, 32'hFFFFFFFF, 32'h2, 0, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_busy", bus.busy, 0);
        check("mrst_done", bus.done, 0);
        check("mrst_hi", bus.hi_out, 0);
        check("mrst_lo", bus.lo_out, 0);
        check("mrst_dz", bus.div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("mrst_quiet", 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
